// File: rtl/tt_mux_pkg.sv
// Shared widths, bus field offsets and FSM encoding for the project mux controller.
package tt_mux_pkg;

    localparam int IW_W = 18;
    localparam int OW_W = 24;

    localparam int IW_CLK   = 0;
    localparam int IW_RST_N = 1;
    localparam int IW_UI    = 2;
    localparam int IW_UIO   = 10;

    localparam int OW_UO      = 0;
    localparam int OW_UIO_OUT = 8;
    localparam int OW_UIO_OE  = 16;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } mux_state_e;

endpackage

// File: rtl/tt_mux_ctrl_if.sv
// Controller <-> project wrapper bus: broadcast iw, one-hot ena, concatenated ow.
interface tt_mux_ctrl_if #(
    parameter int N_PROJ = 4
);
    logic [tt_mux_pkg::IW_W-1:0]        iw;
    logic [N_PROJ-1:0]                  ena;
    logic [N_PROJ*tt_mux_pkg::OW_W-1:0] ow;

    modport master (output iw, output ena, input ow);
    modport slave  (input iw, input ena, output ow);
endinterface

// File: rtl/tt_sync_edge.sv
// Multi-flop synchronizer for an async pin with a rise detector on the synchronized value.
module tt_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        dly_d  = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~dly_q;
endmodule

// File: rtl/tt_mux_ctrl.sv
// Project mux controller: decodes select/enable pins into a one-hot project enable
// and routes pad I/O to and from the selected project wrapper.
module tt_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ      = 4,
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_sel_rst_n,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    input  logic              pad_clk,
    input  logic              pad_rst_n,
    input  logic [7:0]        pad_ui_in,
    input  logic [7:0]        pad_uio_in,
    tt_mux_ctrl_if.master     bus,
    output logic [7:0]        pad_uo_out,
    output logic [7:0]        pad_uio_out,
    output logic [7:0]        pad_uio_oe,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_valid
);
    logic sel_rst_n_s, inc_s, ena_s;
    logic sel_rst_rise, inc_rise, ena_rise;
    logic unused_rise;

    // Select-reset syncs to 0 so the address is held cleared until the pin is seen high.
    tt_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sel_rst (
        .clk(clk), .rst(rst), .din(ctrl_sel_rst_n), .dout(sel_rst_n_s), .rise(sel_rst_rise)
    );
    tt_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_inc (
        .clk(clk), .rst(rst), .din(ctrl_sel_inc), .dout(inc_s), .rise(inc_rise)
    );
    tt_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ena (
        .clk(clk), .rst(rst), .din(ctrl_ena), .dout(ena_s), .rise(ena_rise)
    );

    assign unused_rise = sel_rst_rise ^ ena_rise ^ inc_s;

    mux_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [N_PROJ-1:0] ena_q, ena_d;

    assign sel_valid = (int'(addr_q) < N_PROJ);

    // Any address change drops to OFF in the same cycle, forcing a zero-ena gap.
    always_comb begin
        addr_d  = addr_q;
        state_d = state_q;
        ena_d   = '0;

        if (!sel_rst_n_s) begin
            addr_d = '0;
        end else if (inc_rise) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            ST_OFF: if (ena_s && sel_rst_n_s && sel_valid && !inc_rise) state_d = ST_ON;
            ST_ON:  if (!ena_s || !sel_rst_n_s || inc_rise)             state_d = ST_OFF;
            default: state_d = ST_OFF;
        endcase

        if (state_d == ST_ON) begin
            for (int p = 0; p < N_PROJ; p++) begin
                ena_d[p] = (addr_d == ADDR_W'(p));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            addr_q  <= '0;
            ena_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ena_q   <= ena_d;
        end
    end

    logic [OW_W-1:0] sel_ow;
    logic [IW_W-1:0] iw_w;
    logic            route_en;

    assign route_en = (state_q == ST_ON) && sel_valid;

    always_comb begin
        sel_ow = '0;
        for (int p = 0; p < N_PROJ; p++) begin
            if (addr_q == ADDR_W'(p)) sel_ow = bus.ow[p*OW_W +: OW_W];
        end
    end

    // Projects see clk and rst_n held low whenever nothing is enabled.
    always_comb begin
        iw_w = '0;
        if (state_q == ST_ON) begin
            iw_w[IW_CLK]      = pad_clk;
            iw_w[IW_RST_N]    = pad_rst_n;
            iw_w[IW_UI +: 8]  = pad_ui_in;
            iw_w[IW_UIO +: 8] = pad_uio_in;
        end
    end

    assign bus.iw      = iw_w;
    assign bus.ena     = ena_q;
    assign sel_addr    = addr_q;
    assign pad_uo_out  = route_en ? sel_ow[OW_UO +: 8]      : 8'h00;
    assign pad_uio_out = route_en ? sel_ow[OW_UIO_OUT +: 8] : 8'h00;
    assign pad_uio_oe  = route_en ? sel_ow[OW_UIO_OE +: 8]  : 8'h00;
endmodule

// File: doc/tt_mux_ctrl.md
Name: tt_mux_ctrl

Overview:
- Chip-side controller for the project mux. It is the opposite end of the per-project wrapper interface: it drives each wrapper's ena and 18-bit iw bus, and collects each wrapper's 24-bit ow bus.
- Decodes the three external control pins (select-reset, select-increment, enable) into a project address and a one-hot enable.
- Broadcasts pad inputs on iw and routes the selected project's ow back to the output pads.
- Sits between the pad ring and the N project wrappers.

Parameters:
- N_PROJ, 4: number of attached project wrappers.
- ADDR_W, 5: address counter width; 2**ADDR_W >= N_PROJ required.
- SYNC_STAGES, 2: synchronizer depth for the async control pins; minimum 2.

Ports:
- clk  in  1  controller clock.
- rst  in  1  synchronous, active-high reset.
- ctrl_sel_rst_n  in  1  async; low clears the address.
- ctrl_sel_inc  in  1  async; each rising edge increments the address.
- ctrl_ena  in  1  async; enables the selected project.
- pad_clk  in  1  project clock from pad.
- pad_rst_n  in  1  project reset from pad.
- pad_ui_in  in  8  dedicated inputs.
- pad_uio_in  in  8  bidir inputs.
- iw  out  18  broadcast bus {uio_in[17:10], ui_in[9:2], rst_n[1], clk[0]}.
- ena  out  N_PROJ  one-hot project enable.
- ow  in  N_PROJ*24  project p occupies ow[p*24 +: 24] = {uio_oe[23:16], uio_out[15:8], uo_out[7:0]}.
- pad_uo_out  out  8  to output pads.
- pad_uio_out  out  8  to bidir pads.
- pad_uio_oe  out  8  bidir output enables.
- sel_addr  out  ADDR_W  current address (debug).
- sel_valid  out  1  sel_addr < N_PROJ.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Synchronizers: each ctrl_* pin passes through SYNC_STAGES flops. Reset values are sel_rst_n_s = 0, inc_s = 0, ena_s = 0.
- inc_rise = inc_s & ~inc_s_d (one-cycle pulse).
- Address register:
  - If ~sel_rst_n_s: addr <= 0.
  - Else if inc_rise: addr <= addr + 1, wrapping modulo 2**ADDR_W.
  - Reset wins over a simultaneous inc_rise.
- FSM, states OFF and ON; reset state is OFF.
  - OFF -> ON when ena_s & sel_rst_n_s & sel_valid & ~inc_rise.
  - ON -> OFF when ~ena_s | ~sel_rst_n_s | inc_rise. The address update happens in the same cycle.
  - Result: any address change forces at least one all-zero ena cycle (break-before-make). Two ena bits are never high together.
- ena: registered; equals onehot(addr) in ON, 0 in OFF.
- Latency:
  - ctrl_ena rising (address valid, stable) -> ena high after SYNC_STAGES+1 clk edges.
  - ctrl_ena falling -> ena low after SYNC_STAGES+1 edges.
- iw: combinational.
  - In ON: {pad_uio_in, pad_ui_in, pad_rst_n, pad_clk}.
  - In OFF: 18'b0, so every project sees clk low and rst_n low.
- Pad outputs: combinational from registered state/addr.
  - In ON: the ow slice of addr (zero added latency from ow).
  - In OFF or ~sel_valid: all 0. uio_oe = 0 puts the bidirs in input mode.
- sel_valid: combinational from addr. Out-of-range addresses never enable anything.
- Reset mid-operation: the next edge gives addr 0, state OFF, ena 0, iw 0, pads 0, synchronizers cleared.
- Control pulses shorter than SYNC_STAGES+1 cycles high or low may be lost; this is acceptable and documented.

Decomposition:
- Package tt_mux_pkg:
  - IW_W = 18, OW_W = 24.
  - Field offsets: IW_CLK = 0, IW_RST_N = 1, IW_UI = 2, IW_UIO = 10; OW_UO = 0, OW_UIO_OUT = 8, OW_UIO_OE = 16.
  - FSM state enum.
- Sub-module tt_sync_edge: SYNC_STAGES synchronizer plus registered rise detector, parameterized reset value. Instantiated three times.

Test Plan:
- Reset: hold rst 3 cycles with ctrl_* toggling -> ena = 0, iw = 0, pads = 0, sel_addr = 0, state OFF.
- Select project 2 (N_PROJ = 4):
  - Stimulus: sel_rst_n = 1; two inc pulses of 4 cycles high/low each; then ctrl_ena = 1; ow[2] = 24'hA5C35A.
  - Response: sel_addr = 2; ena = 4'b0100 exactly 3 edges after the ctrl_ena rise; pad_uo_out = 8'h5A, pad_uio_out = 8'hC3, pad_uio_oe = 8'hA5; iw mirrors the pads.
- Switch while active: from project 2 enabled, one inc pulse -> ena = 0 for at least 1 cycle, then 4'b1000. A monitor asserts $onehot0(ena) every cycle.
- Invalid/wrap:
  - 4 incs with ctrl_ena = 1 -> sel_addr = 4, sel_valid = 0, ena = 0, pads 0.
  - 32 incs total -> sel_addr wraps to 0.
- Mid-operation select reset: drive ctrl_sel_rst_n low while project 3 is on -> within 3 edges ena = 0 and sel_addr = 0. Force inc_rise in the same cycle -> sel_addr stays 0.
- Mid-operation rst: assert rst with project 1 on -> next edge ena = 0, iw = 0, pads = 0. After release, ena stays 0 until ctrl_ena is re-synchronized.
